instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch stage directly upstream of control_unit. Holds the PC and issues one
//  word request at a time to instruction memory. Buffers returned words in a small FIFO and
//  presents each word, its PC and its opcode field (instr[6:0]) over a valid/ready handshake.
//  Accepts a redirect (branch/jump target) that flushes everything younger than the redirect.
// PARAMETERS
//  XLEN        32      data and address width in bits
//  RESET_PC    32'h0   first fetch address after reset; bits [1:0] must be 0
//  BUF_DEPTH   2       fetch buffer entries; power of two, >= 2
// PORTS
//  clk            in   1      single clock; all state updates on the rising edge
//  rst_n          in   1      synchronous reset, active-low
//  imem_req       out  1      fetch request valid
//  imem_addr      out  XLEN   word-aligned fetch address
//  imem_gnt       in   1      request accepted this cycle (imem_req && imem_gnt)
//  imem_rvalid    in   1      read data valid, one per accepted request, >= 1 cycle after gnt
//  imem_rdata     in   XLEN   instruction word
//  redirect_valid in   1      load new PC and flush
//  redirect_pc    in   XLEN   redirect target; bits [1:0] forced to 0
//  instr_valid    out  1      instr, instr_pc and opcode hold a valid instruction
//  instr_ready    in   1      consumer accepts; pop on instr_valid && instr_ready
//  instr          out  XLEN   instruction word at buffer head
//  instr_pc       out  XLEN   PC of instr
//  opcode         out  7      instr[6:0]; drives control_unit.opcode
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): pc=RESET_PC, state=IDLE, buffer empty, drop=0; imem_req=0,
//   instr_valid=0, instr=0, instr_pc=0, opcode=0. Reset mid-transaction abandons any
//   outstanding request; a later imem_rvalid for it is ignored (rvalid is ignored in IDLE).
//  FSM, at most one outstanding request:
//   IDLE: imem_req=0; next state REQ. Exactly one idle cycle after reset release.
//   REQ:  imem_req=1 iff count<BUF_DEPTH; imem_addr=pc. On grant: pc<=pc+4 (mod 2^XLEN),
//         -> WAIT. Without a grant, imem_req stays high and imem_addr stays stable.
//   WAIT: imem_req=0. On imem_rvalid: push {rdata,pc_of_req} unless drop=1, clear drop,
//         -> REQ. Slot is reserved (count<DEPTH at issue), so a push never overflows.
//  Latency: grant at cycle t, rvalid at t+k -> instr_valid at t+k+1 when the buffer was
//   empty. Back-to-back fetch rate is one word per (k+1) cycles.
//  Output: instr_valid = (count!=0); instr, instr_pc and opcode are combinational from the
//   buffer head and are 0 when empty. Data is held stable while valid && !ready.
//  Redirect (highest priority, any state except during reset):
//   - Buffer is flushed; a pop in the same cycle is discarded, and instr_valid=0 next cycle.
//   - pc <= {redirect_pc[XLEN-1:2],2'b00}.
//   - REQ without grant: the request is withdrawn next cycle and reissued with the new pc.
//   - REQ with grant in the same cycle: -> WAIT with drop=1; pc=redirect target.
//   - WAIT: drop<=1. If rvalid arrives in the same cycle, that word is dropped, drop stays
//     0, and the FSM -> REQ.
//  Simultaneous push and pop: both take effect; count is unchanged.
//  pc_of_req is captured at grant, so the pushed PC is the PC of the request actually sent.
// STRUCTURE
//  cpu_pkg: XLEN; opcode constants OP_RTYPE=7'b0110011, OP_ITYPE=7'b0010011,
//   OP_LOAD=7'b0000011, OP_STORE=7'b0100011; fetch FSM state enum {IDLE,REQ,WAIT}.
//  Sub-module fetch_buffer: synchronous FIFO of BUF_DEPTH x (2*XLEN), with push, pop, flush,
//   count, and combinational head. Flush has priority over push and pop.
//  instr_fetch contains the FSM, pc, pc_of_req, drop, and one fetch_buffer instance.
// TESTING
//  1 Reset, then zero-wait memory (gnt=1, rvalid 1 cycle later), ready=1 -> imem_addr
//    0,4,8 in successive requests; instr_pc 0,4,8 in order; opcode = rdata[6:0].
//  2 ready=0 held -> exactly 2 words buffered; imem_req=0 thereafter. Raise ready -> both
//    words pop in order, then fetching resumes at addr 8.
//  3 Redirect to 32'h103 in WAIT, with rvalid 2 cycles later -> the returned word is not
//    presented. Next imem_addr = 32'h100, and instr_pc of the first valid word = 32'h100.
//  4 gnt=0 for 5 cycles -> imem_req=1 and imem_addr stable for all 5 cycles. Redirect on the
//    3rd cycle -> imem_addr changes to the new target one cycle later.
//  5 rst_n=0 for one edge while in WAIT, then rvalid arrives -> no instr_valid. The first
//    request after reset goes to RESET_PC, after one idle cycle.
//  6 Redirect and pop in the same cycle with 2 words buffered -> instr_valid=0 next cycle,
//    and count=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, base opcodes and the fetch FSM state type.
// Latency: none (definitions only).
// Backpressure: not applicable.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Fetch buffer: small synchronous FIFO holding {instr, pc} pairs with a combinational head.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push is ignored when full, pop when empty; flush beats both.
module fetch_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && (count_q != FULL);
  assign pop_ok  = pop && (count_q != '0);

  // Storage is never cleared: validity comes only from the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem_q[wr_q] <= push_data;
    end
  end

  // Pointer and occupancy tracking; flush empties the FIFO regardless of push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      count_q <= count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

  assign count = count_q;
  assign head  = (count_q != '0) ? mem_q[rd_q] : '0;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC + single-outstanding memory request FSM feeding a small word buffer.
// Latency: rvalid at cycle n -> instr_valid at n+1 when the buffer was empty.
// Backpressure: instr_ready low fills the buffer; requests stop while no free slot remains.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      opcode
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_req_q, pc_req_d;
  logic            drop_q, drop_d;

  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] head;
  logic              buf_full;
  logic              gnt_fire;
  logic              rsp_fire;
  logic              push;
  logic              pop;

  // A slot is reserved at issue time, so requests are only raised with room left.
  assign buf_full = (count == CW'(BUF_DEPTH));
  assign imem_req  = (state_q == REQ) && !buf_full;
  assign imem_addr = pc_q;
  assign gnt_fire  = imem_req && imem_gnt;
  assign rsp_fire  = (state_q == WAIT) && imem_rvalid;

  // Words belonging to a request older than a redirect are discarded, never buffered.
  assign push = rsp_fire && !drop_q && !redirect_valid;
  assign pop  = instr_valid && instr_ready;

  // Next-state logic: FSM transitions, PC advance and redirect handling.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_req_d = pc_req_q;
    drop_d   = drop_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (gnt_fire) begin
          state_d  = WAIT;
          pc_req_d = pc_q;
          pc_d     = pc_q + XLEN'(4);
          // A redirect racing the grant makes the in-flight word stale.
          drop_d   = redirect_valid;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = REQ;
          drop_d  = 1'b0;
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redirect_valid) begin
      pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end
  end

  // State registers; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      pc_req_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_req_q <= pc_req_d;
      drop_q   <= drop_d;
    end
  end

  fetch_buffer #(
    .WIDTH (2 * XLEN),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({imem_rdata, pc_req_q}),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );

  assign instr_valid = (count != '0);
  assign instr       = head[2*XLEN-1:XLEN];
  assign instr_pc    = head[XLEN-1:0];
  assign opcode      = head[XLEN+6:XLEN];

endmodule
